// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: pulses PLL RESETB, waits for a stable LOCK, then releases the pixel-domain reset.
// Optional loss counter enabled with `define PLL_LOCK_SEQ_STATS_EN.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 8000,
  parameter int STABLE_CYCLES = 1600,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 14
) (
  input  logic       clock_in,
  input  logic       resetn,
  input  logic       pll_locked,
  output logic       pll_resetb,
  output logic       sys_resetn,
  output logic       ready,
  output logic       fault,
`ifdef PLL_LOCK_SEQ_STATS_EN
  output logic [7:0] loss_count,
`endif
  output logic [3:0] retries
);

  // state     | meaning
  // PLL_RST   | pll_resetb held low for RST_CYCLES
  // WAIT_LOCK | PLL released, waiting for synced lock or timeout
  // STABLE    | lock high, counting STABLE_CYCLES of continuous lock
  // RUN       | downstream reset released, ready high
  // FAULT     | retries exhausted; only resetn leaves
  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       MAX_R       = 4'(MAX_RETRIES);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [3:0]       retries_next, retries_inc;
  logic             sync1, lk;

  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b0;
      lk    <= 1'b0;
    end else begin
      sync1 <= pll_locked;
      lk    <= sync1;
    end
  end

  assign retries_inc = (retries == MAX_R) ? retries : retries + 4'd1;

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    retries_next = retries;
    case (state)
      PLL_RST: begin
        if (cnt == RST_LAST) begin
          cnt_next   = '0;
          state_next = WAIT_LOCK;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      WAIT_LOCK: begin
        // lock takes priority over a coincident timeout
        if (lk) begin
          cnt_next   = '0;
          state_next = STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          cnt_next     = '0;
          retries_next = retries_inc;
          state_next   = (retries_inc == MAX_R) ? FAULT : PLL_RST;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      STABLE: begin
        if (!lk) begin
          cnt_next   = '0;
          state_next = WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          cnt_next     = '0;
          retries_next = 4'd0;
          state_next   = RUN;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      RUN: begin
        if (!lk) begin
          cnt_next   = '0;
          state_next = PLL_RST;
        end
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        cnt_next   = '0;
        state_next = PLL_RST;
      end
    endcase
  end

  // outputs registered from the next state so they change on the same edge as state
  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      state      <= PLL_RST;
      cnt        <= '0;
      retries    <= 4'd0;
      pll_resetb <= 1'b0;
      sys_resetn <= 1'b0;
      ready      <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      retries    <= retries_next;
      pll_resetb <= (state_next != PLL_RST) && (state_next != FAULT);
      sys_resetn <= (state_next == RUN);
      ready      <= (state_next == RUN);
      fault      <= (state_next == FAULT);
    end
  end

`ifdef PLL_LOCK_SEQ_STATS_EN
  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      loss_count <= 8'd0;
    end else if (state == RUN && state_next == PLL_RST && loss_count != 8'hFF) begin
      loss_count <= loss_count + 8'd1;
    end
  end
`endif

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Sequences bring-up of the iCE40 SB_PLL40_CORE wrapper (16 MHz in, 216 MHz pixel clock out) for the VGA path.
- Runs on the 16 MHz board clock.
- Drives PLL RESETB and watches LOCK. Releases the downstream reset only after lock has been stable for a set time.
- Retries on lock timeout and re-sequences on lock loss.

Parameters:
- RST_CYCLES, 16: clock_in cycles that pll_resetb is held low per attempt (min 1).
- LOCK_TIMEOUT, 8000: cycles allowed in WAIT_LOCK before the attempt fails (500 us at 16 MHz).
- STABLE_CYCLES, 1600: consecutive synced-lock-high cycles required before release (100 us).
- MAX_RETRIES, 3: failed attempts allowed before FAULT (1..15).
- CNT_W, 14: width of the shared cycle counter. Must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

Ports:
- clock_in  input  1  16 MHz board clock; the only clock.
- resetn  input  1  asynchronous active-low reset.
- pll_locked  input  1  PLL LOCK, asynchronous to clock_in.
- pll_resetb  output  1  to PLL RESETB; low holds the PLL in reset.
- sys_resetn  output  1  active-low reset for pixel-domain logic; the consumer resynchronises it.
- ready  output  1  high while in RUN.
- fault  output  1  sticky; high in FAULT.
- retries  output  4  failed attempts in the current bring-up.

Behaviour:
- Async active-low reset; all flops clear on resetn low regardless of clock.
- Reset values: state=PLL_RST, pll_resetb=0, sys_resetn=0, ready=0, fault=0, retries=0, counter=0, sync flops=0.
- pll_locked passes through a 2-flop synchroniser. lk = second stage. The FSM uses only lk.
- All outputs are registered and decoded from state, so there are no glitches.
- PLL_RST:
  - pll_resetb=0. Counter increments each cycle.
  - When counter==RST_CYCLES-1: counter clears, go to WAIT_LOCK.
- WAIT_LOCK:
  - pll_resetb=1.
  - If lk=1: clear counter, go to STABLE.
  - Else if counter==LOCK_TIMEOUT-1: clear counter, retries+1.
    - If the new retries==MAX_RETRIES, go to FAULT.
    - Otherwise go to PLL_RST.
  - Else increment counter.
  - If lk and timeout happen in the same cycle, lk wins.
- STABLE:
  - pll_resetb=1.
  - If lk=0: clear counter, go back to WAIT_LOCK. The timeout restarts and retries is unchanged.
  - If counter==STABLE_CYCLES-1 with lk=1: go to RUN.
- RUN:
  - pll_resetb=1, sys_resetn=1, ready=1. retries clears on entry.
  - If lk=0: go to PLL_RST. sys_resetn and ready are driven low on the next edge, i.e. 3 cycles after a raw LOCK drop (2 sync + 1).
- FAULT:
  - pll_resetb=0, sys_resetn=0, ready=0, fault=1.
  - Terminal; left only via resetn.
- Latency from resetn release with LOCK already high: RST_CYCLES + 1 (first WAIT_LOCK cycle) + STABLE_CYCLES cycles until ready=1. The synchroniser fills during PLL_RST.
- Counter uses compare-equal, so it never wraps.
- retries saturates at MAX_RETRIES.

Optional Feature:
- PLL_LOCK_SEQ_STATS_EN defined:
  - Adds output loss_count [7:0], reset 0.
  - Increments on every RUN→PLL_RST transition.
  - Saturates at 255; cleared only by resetn.
- Not defined: the port and its counter are absent; all other behaviour is identical.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=64, STABLE_CYCLES=16, MAX_RETRIES=3):
- LOCK tied high, release resetn → pll_resetb rises after 4 cycles; ready and sys_resetn rise 21 cycles after release; retries=0, fault=0.
- LOCK held low → three 64-cycle WAIT_LOCK windows, each preceded by a 4-cycle pll_resetb low pulse; retries steps 1, 2, 3; then FAULT, fault=1, pll_resetb=0 held until resetn.
- LOCK drops for 1 cycle at counter=10 in STABLE → returns to WAIT_LOCK, then needs a full 16 fresh cycles; ready stays 0; retries unchanged.
- In RUN, LOCK falls → sys_resetn=0 exactly 3 cycles later, then a pll_resetb 4-cycle pulse; with LOCK restored, ready returns; loss_count=1 (macro on).
- Assert resetn low mid-STABLE → all outputs hit reset values immediately, before the next clock edge; on release, sequencing restarts from PLL_RST.
- LOCK rises in the exact cycle counter==63 in WAIT_LOCK → goes to STABLE; retries not incremented.
